frame_header_gen: RTL and testbench

Parametrised frame framer for the dscope acquisition stream. On a frame sync it snapshots a magic word, N user header fields and a payload length. It then emits them as a header, passes exactly that many payload words from the frame source, and optionally appends a checksum trailer. It sits between the frame buffer and the output packetiser, with valid/ready handshaking on both the payload input and the output.

---
 rtl/frame_header_gen.sv | 167 ++++++++++++++++
 tb/tb_frame_header_gen.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_header_gen.sv
// Frame framer: emits magic word, captured header fields, a pass-through payload of the
// captured length and an optional checksum trailer, with valid/ready on both sides.
module frame_header_gen #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned N_FIELDS   = 3,
    parameter int unsigned LEN_W      = 16,
    parameter logic [31:0] MAGIC      = 32'hEC534F4D,
    parameter bit          TRAILER_EN = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_sync,
    input  logic [N_FIELDS*DATA_W-1:0]   i_fields,
    input  logic [LEN_W-1:0]             i_payload_len,
    output logic [15:0]                  o_header_size,
    input  logic [DATA_W-1:0]            i_frame_data,
    input  logic                         i_frame_vld,
    output logic                         o_frame_rdy,
    output logic [DATA_W-1:0]            o_out_data,
    output logic                         o_out_vld,
    input  logic                         i_out_rdy,
    output logic                         o_busy,
    output logic                         o_overrun
);

    localparam int unsigned       IDX_W   = 4;
    localparam logic [DATA_W-1:0] MAGIC_W = DATA_W'(MAGIC);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MAGIC,
        ST_FIELD,
        ST_PAYLOAD,
        ST_TRAILER
    } state_t;

    state_t                       state_q, state_d;
    logic [N_FIELDS*DATA_W-1:0]   fields_q, fields_d;
    logic [LEN_W-1:0]             rem_q, rem_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [DATA_W-1:0]            csum_q, csum_d;
    logic                         pending_q, pending_d;
    logic                         overrun_q, overrun_d;
    logic                         out_xfer;
    state_t                       after_body;

    assign o_header_size = 16'(1 + N_FIELDS);
    assign o_busy        = (state_q != ST_IDLE);
    assign o_overrun     = overrun_q;
    assign out_xfer      = o_out_vld & i_out_rdy;
    assign after_body    = TRAILER_EN ? ST_TRAILER : ST_IDLE;

    // Output mux is decoded from the state register so an async reset blanks it at once.
    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        o_out_data  = '0;
        o_out_vld   = 1'b0;
        o_frame_rdy = 1'b0;
        case (state_q)
            ST_MAGIC: begin
                o_out_data = MAGIC_W;
                o_out_vld  = 1'b1;
            end
            ST_FIELD: begin
                o_out_data = fields_q[32'(idx_q)*DATA_W +: DATA_W];
                o_out_vld  = 1'b1;
            end
            ST_PAYLOAD: begin
                o_out_data  = i_frame_data;
                o_out_vld   = i_frame_vld;
                o_frame_rdy = i_out_rdy;
            end
            ST_TRAILER: begin
                o_out_data = csum_q;
                o_out_vld  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        fields_d  = fields_q;
        rem_d     = rem_q;
        idx_d     = idx_q;
        csum_d    = csum_q;
        pending_d = pending_q;
        overrun_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_sync || pending_q) begin
                    fields_d  = i_fields;
                    rem_d     = i_payload_len;
                    idx_d     = '0;
                    csum_d    = '0;
                    state_d   = ST_MAGIC;
                    // A queued sync is consumed now; a fresh sync this cycle queues behind it.
                    pending_d = pending_q && i_sync;
                end
            end
            ST_MAGIC: begin
                if (out_xfer) begin
                    csum_d  = csum_q + o_out_data;
                    state_d = ST_FIELD;
                end
            end
            ST_FIELD: begin
                if (out_xfer) begin
                    csum_d = csum_q + o_out_data;
                    if (idx_q == IDX_W'(N_FIELDS - 1)) begin
                        state_d = (rem_q != '0) ? ST_PAYLOAD : after_body;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_PAYLOAD: begin
                if (out_xfer) begin
                    csum_d = csum_q + o_out_data;
                    rem_d  = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = after_body;
                    end
                end
            end
            ST_TRAILER: begin
                if (out_xfer) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A sync during a frame (including its final transfer) is queued one deep.
        if (state_q != ST_IDLE && i_sync) begin
            if (pending_q) begin
                overrun_d = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the values from before the clock edge regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            fields_q  <= '0;
            rem_q     <= '0;
            idx_q     <= '0;
            csum_q    <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fields_q  <= fields_d;
            rem_q     <= rem_d;
            idx_q     <= idx_d;
            csum_q    <= csum_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

endmodule

// File: tb/tb_frame_header_gen.sv
// Scoreboard bench for frame_header_gen: expected words are queued when a frame is
// launched and compared as the DUT transfers them.
module tb_frame_header_gen;

    localparam logic [31:0] MAGIC = 32'hEC534F4D;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_sync;
    logic [95:0] i_fields;
    logic [15:0] i_payload_len;
    logic [15:0] o_header_size;
    logic [31:0] i_frame_data = '0;
    logic        i_frame_vld  = 1'b0;
    logic        o_frame_rdy;
    logic [31:0] o_out_data;
    logic        o_out_vld;
    logic        i_out_rdy;
    logic        o_busy;
    logic        o_overrun;

    frame_header_gen dut (
        .clk           (clk),
        .rst           (rst),
        .i_sync        (i_sync),
        .i_fields      (i_fields),
        .i_payload_len (i_payload_len),
        .o_header_size (o_header_size),
        .i_frame_data  (i_frame_data),
        .i_frame_vld   (i_frame_vld),
        .o_frame_rdy   (o_frame_rdy),
        .o_out_data    (o_out_data),
        .o_out_vld     (o_out_vld),
        .i_out_rdy     (i_out_rdy),
        .o_busy        (o_busy),
        .o_overrun     (o_overrun)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    logic [31:0] exp_q [$];
    logic [31:0] pay_q [$];
    int          xfer_cyc [$];
    int          cyc         = 0;
    int          busy_cycles = 0;
    int          ovr_cnt     = 0;
    bit          rdy_seen    = 1'b0;
    bit          pay_take    = 1'b0;
    bit          held_vld    = 1'b0;
    logic [31:0] held_word   = '0;
    logic [31:0] last_word   = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Payload source: presents the head of pay_q and pops it after each accepted transfer.
    always @(negedge clk) pay_take = i_frame_vld && o_frame_rdy && !rst;
    always @(posedge clk) begin
        #1;
        if (pay_take && pay_q.size() > 0) void'(pay_q.pop_front());
        i_frame_vld  = (pay_q.size() > 0);
        i_frame_data = (pay_q.size() > 0) ? pay_q[0] : '0;
    end

    // Output monitor: scoreboard compare on every output transfer, stability while stalled.
    always @(negedge clk) begin
        if (rst) begin
            held_vld = 1'b0;
        end else begin
            if (o_busy)      busy_cycles++;
            if (o_overrun)   ovr_cnt++;
            if (o_frame_rdy) rdy_seen = 1'b1;
            if (held_vld) check("hold", o_out_data, held_word);
            if (o_out_vld && i_out_rdy) begin
                if (exp_q.size() == 0) begin
                    check("spurious_word", o_out_vld, 1'b0);
                end else begin
                    check("word", o_out_data, exp_q.pop_front());
                end
                last_word = o_out_data;
                xfer_cyc.push_back(cyc);
                held_vld = 1'b0;
            end else if (o_out_vld) begin
                held_vld  = 1'b1;
                held_word = o_out_data;
            end else begin
                held_vld = 1'b0;
            end
        end
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Queues the expected output words of one frame and its payload words.
    task automatic push_frame(input logic [31:0] f [3], input logic [31:0] p [4], input int n);
        logic [31:0] sum;
        sum = MAGIC;
        exp_q.push_back(MAGIC);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(f[i]);
            sum = sum + f[i];
        end
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(p[i]);
            pay_q.push_back(p[i]);
            sum = sum + p[i];
        end
        exp_q.push_back(sum);
    endtask

    task automatic do_sync(input logic [31:0] f [3], input int n);
        i_fields      = {f[2], f[1], f[0]};
        i_payload_len = 16'(n);
        i_sync        = 1'b1;
        @(posedge clk); #1;
        i_sync = 1'b0;
    endtask

    task automatic wait_drain(input bit toggle);
        int n = 0;
        while ((exp_q.size() != 0 || o_busy) && n < 400) begin
            @(posedge clk); #1;
            if (toggle) i_out_rdy = !i_out_rdy;
            n++;
        end
        i_out_rdy = 1'b1;
        check("drain", exp_q.size(), 0);
    endtask

    logic [31:0] f123 [3] = '{32'd1, 32'd2, 32'd3};
    logic [31:0] f000 [3] = '{32'd0, 32'd0, 32'd0};
    logic [31:0] f456 [3] = '{32'd4, 32'd5, 32'd6};
    logic [31:0] f789 [3] = '{32'd7, 32'd8, 32'd9};
    logic [31:0] p1020 [4] = '{32'h10, 32'h20, 32'h0, 32'h0};
    logic [31:0] pwrap [4] = '{32'hFFFFFFFF, 32'h2, 32'h0, 32'h0};
    logic [31:0] pone  [4] = '{32'h55, 32'h0, 32'h0, 32'h0};
    logic [31:0] pfour [4] = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};

    initial begin
        rst = 1'b1; i_sync = 1'b0; i_fields = '0; i_payload_len = '0; i_out_rdy = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_vld", o_out_vld, 1'b0);
        check("rst_out_data", o_out_data, 32'h0);
        check("rst_frame_rdy", o_frame_rdy, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_overrun", o_overrun, 1'b0);
        check("header_size", o_header_size, 16'd4);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic frame, output always ready.
        push_frame(f123, p1020, 2);
        @(posedge clk); #1;
        busy_cycles = 0;
        do_sync(f123, 2);
        wait_drain(1'b0);
        check("t1_busy_cycles", busy_cycles, 7);
        check("t1_trailer", last_word, 32'hEC534F83);

        // Same frame with output ready toggling every cycle.
        push_frame(f123, p1020, 2);
        @(posedge clk); #1;
        do_sync(f123, 2);
        wait_drain(1'b1);
        check("t2_trailer", last_word, 32'hEC534F83);

        // Zero-length payload.
        @(posedge clk); #1;
        rdy_seen = 1'b0;
        push_frame(f123, p1020, 0);
        do_sync(f123, 0);
        wait_drain(1'b0);
        check("t3_rdy_never", rdy_seen, 1'b0);
        check("t3_trailer", last_word, 32'hEC534F53);

        // Checksum wrap-around.
        push_frame(f000, pwrap, 2);
        @(posedge clk); #1;
        do_sync(f000, 2);
        wait_drain(1'b0);
        check("t4_trailer", last_word, 32'hEC534F4E);

        // Two syncs during a frame: first queued, second overruns.
        @(posedge clk); #1;
        xfer_cyc.delete();
        ovr_cnt = 0;
        push_frame(f123, p1020, 2);
        do_sync(f123, 2);
        i_fields      = {f456[2], f456[1], f456[0]};
        i_payload_len = 16'd1;
        push_frame(f456, pone, 1);
        @(posedge clk); #1; i_sync = 1'b1;
        @(posedge clk); #1; i_sync = 1'b0;
        @(posedge clk); #1; i_sync = 1'b1;
        @(posedge clk); #1; i_sync = 1'b0;
        wait_drain(1'b0);
        check("t5_overrun_pulses", ovr_cnt, 1);
        check("t5_xfer_count", xfer_cyc.size(), 13);
        if (xfer_cyc.size() >= 8) check("t5_idle_gap", xfer_cyc[7] - xfer_cyc[6], 2);

        // Reset in the middle of the payload.
        push_frame(f789, pfour, 4);
        @(posedge clk); #1;
        do_sync(f789, 4);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("t6_in_payload", o_frame_rdy, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("t6_rst_vld", o_out_vld, 1'b0);
        check("t6_rst_data", o_out_data, 32'h0);
        check("t6_rst_busy", o_busy, 1'b0);
        check("t6_rst_rdy", o_frame_rdy, 1'b0);
        exp_q.delete();
        pay_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t6_idle_after_rst", o_busy, 1'b0);
        @(posedge clk); #1;
        push_frame(f123, p1020, 2);
        @(posedge clk); #1;
        do_sync(f123, 2);
        wait_drain(1'b0);
        check("t6_clean_trailer", last_word, 32'hEC534F83);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
